// File: rtl/surfctl_align_sequencer.sv
// Wishbone initiator that aligns one SURF link: tap sweep, eye centring, bitslip lock, link enable.
// Optional per-tap error map output guarded by SURFCTL_ALIGN_ERRMAP_EN.
module surfctl_align_sequencer #(
    parameter int          NUM_TAPS      = 32,
    parameter logic [23:0] INTERVAL      = 24'd65536,
    parameter int          WAIT_CYCLES   = 4096,
    parameter int          ERR_THRESHOLD = 0,
    parameter int          MIN_EYE       = 4,
    parameter int          MAX_BITSLIP   = 8,
    parameter logic [31:0] COUT_PATTERN  = 32'hA55A6996,
    parameter logic [7:0]  DOUT_PATTERN  = 8'h6A,
    parameter int          WB_TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        target_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [1:0]  fail_code_o,
    output logic [5:0]  best_delay_o,
    output logic [6:0]  eye_width_o,
    output logic [3:0]  bitslip_count_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [5:0]  m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
`ifdef SURFCTL_ALIGN_ERRMAP_EN
    output logic [NUM_TAPS-1:0] errmap_o,
`endif
    input  logic        m_err_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_INT, S_TAP_WR, S_TAP_WAIT, S_TAP_RD, S_EVAL, S_SET_CTR,
        S_DAT_RD, S_SLIP, S_CTRL_RD, S_CTRL_WR, S_DONE, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic        target_q, target_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [1:0]  code_q, code_d;
    logic [5:0]  best_delay_q, best_delay_d;
    logic [6:0]  eye_width_q, eye_width_d;
    logic [3:0]  slip_q, slip_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [5:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [31:0] wait_q, wait_d;
    logic [6:0]  tap_q, tap_d;
    logic [31:0] rd_q, rd_d, ctrl_q, ctrl_d;
    logic [5:0]  run_start_q, run_start_d, best_start_q, best_start_d;
    logic [6:0]  run_len_q, run_len_d, best_len_q, best_len_d;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
    logic [NUM_TAPS-1:0] errmap_q, errmap_d;
`endif

    logic        is_bus, ack_ok, req_we, good, last, closing, pat_ok;
    logic [5:0]  base, req_off, n_start, c_start, fb_start;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic [6:0]  n_len, c_len, fb_len;

    always_comb begin
        // Run tracking: the last tap closes whatever run is still open.
        good     = rd_q <= 32'(ERR_THRESHOLD);
        last     = tap_q == 7'(NUM_TAPS - 1);
        n_len    = good ? run_len_q + 7'd1 : 7'd0;
        n_start  = (good && run_len_q == 7'd0) ? tap_q[5:0] : run_start_q;
        c_len    = good ? n_len : run_len_q;
        c_start  = good ? n_start : run_start_q;
        closing  = !good || last;
        fb_len   = best_len_q;
        fb_start = best_start_q;
        if (closing && c_len > best_len_q) begin
            fb_len   = c_len;
            fb_start = c_start;
        end
        pat_ok = target_q ? (m_dat_i[7:0] == DOUT_PATTERN) : (m_dat_i == COUT_PATTERN);
        base   = target_q ? 6'h10 : 6'h00;

        is_bus  = 1'b0;
        req_we  = 1'b0;
        req_off = 6'h00;
        req_dat = 32'h0;
        req_sel = 4'hF;
        case (state_q)
            S_SET_INT: begin is_bus = 1'b1; req_we = 1'b1; req_off = 6'h08; req_dat = {8'h0, INTERVAL}; end
            S_TAP_WR:  begin is_bus = 1'b1; req_we = 1'b1; req_off = 6'h04; req_dat = {26'h0, tap_q[5:0]}; end
            S_TAP_RD:  begin is_bus = 1'b1; req_off = 6'h08; end
            S_SET_CTR: begin is_bus = 1'b1; req_we = 1'b1; req_off = 6'h04; req_dat = {26'h0, best_delay_q}; end
            S_DAT_RD:  begin is_bus = 1'b1; req_off = 6'h0C; end
            S_SLIP:    begin is_bus = 1'b1; req_we = 1'b1; req_off = 6'h0C; end
            S_CTRL_RD: begin is_bus = 1'b1; req_off = 6'h00; end
            S_CTRL_WR: begin is_bus = 1'b1; req_we = 1'b1; req_off = 6'h00; req_dat = ctrl_q | 32'h100; req_sel = 4'b0010; end
            default: ;
        endcase

        state_d = state_q;  target_d = target_q;  busy_d = busy_q;  done_d = done_q;
        fail_d = fail_q;    code_d = code_q;      best_delay_d = best_delay_q;
        eye_width_d = eye_width_q;  slip_d = slip_q;
        cyc_d = cyc_q;  stb_d = stb_q;  we_d = we_q;  adr_d = adr_q;  dat_d = dat_q;  sel_d = sel_q;
        to_cnt_d = to_cnt_q;  wait_d = wait_q;  tap_d = tap_q;  rd_d = rd_q;  ctrl_d = ctrl_q;
        run_start_d = run_start_q;  run_len_d = run_len_q;
        best_start_d = best_start_q;  best_len_d = best_len_q;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
        errmap_d = errmap_q;
`endif
        ack_ok = 1'b0;

        // Each bus state issues exactly one transaction; a fresh one starts only with cyc low.
        if (is_bus) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;  stb_d = 1'b1;  we_d = req_we;
                adr_d = base + req_off;  dat_d = req_dat;  sel_d = req_sel;  to_cnt_d = 16'h0;
            end else if (m_err_i || (m_ack_i && !we_q && m_dat_i == 32'hFFFFFFFF) ||
                         (!m_ack_i && to_cnt_q == 16'(WB_TIMEOUT - 1))) begin
                cyc_d = 1'b0;  stb_d = 1'b0;  code_d = 2'd1;  state_d = S_FAIL;
            end else if (m_ack_i) begin
                cyc_d = 1'b0;  stb_d = 1'b0;  ack_ok = 1'b1;  rd_d = m_dat_i;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: if (start_i) begin
                target_d = target_i;  busy_d = 1'b1;  done_d = 1'b0;  fail_d = 1'b0;  code_d = 2'd0;
                best_delay_d = 6'h0;  eye_width_d = 7'h0;  slip_d = 4'h0;  tap_d = 7'h0;
                run_start_d = 6'h0;  run_len_d = 7'h0;  best_start_d = 6'h0;  best_len_d = 7'h0;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
                errmap_d = '0;
`endif
                state_d = S_SET_INT;
            end
            S_SET_INT: if (ack_ok) state_d = S_TAP_WR;
            S_TAP_WR:  if (ack_ok) begin wait_d = 32'h0; state_d = S_TAP_WAIT; end
            S_TAP_WAIT: begin
                wait_d = wait_q + 32'd1;
                if (wait_q >= 32'(WAIT_CYCLES - 1)) state_d = S_TAP_RD;
            end
            S_TAP_RD:  if (ack_ok) state_d = S_EVAL;
            S_EVAL: begin
                run_len_d = n_len;  run_start_d = n_start;
                best_len_d = fb_len;  best_start_d = fb_start;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
                for (int t = 0; t < NUM_TAPS; t++)
                    if (tap_q == 7'(t)) errmap_d[t] = !good;
`endif
                if (last) begin
                    eye_width_d = fb_len;
                    if (fb_len < 7'(MIN_EYE)) begin
                        code_d = 2'd2;  state_d = S_FAIL;
                    end else begin
                        best_delay_d = fb_start + fb_len[6:1];
                        state_d = S_SET_CTR;
                    end
                end else begin
                    tap_d = tap_q + 7'd1;  state_d = S_TAP_WR;
                end
            end
            S_SET_CTR: if (ack_ok) state_d = S_DAT_RD;
            S_DAT_RD: if (ack_ok) begin
                if (pat_ok)                          state_d = S_CTRL_RD;
                else if (slip_q == 4'(MAX_BITSLIP)) begin code_d = 2'd3; state_d = S_FAIL; end
                else                                 state_d = S_SLIP;
            end
            S_SLIP:    if (ack_ok) begin slip_d = slip_q + 4'd1; state_d = S_DAT_RD; end
            S_CTRL_RD: if (ack_ok) begin ctrl_d = m_dat_i; state_d = S_CTRL_WR; end
            S_CTRL_WR: if (ack_ok) state_d = S_DONE;
            S_DONE:    begin done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE; end
            S_FAIL:    begin fail_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE; end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;  target_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
            fail_q <= 1'b0;  code_q <= 2'd0;  best_delay_q <= 6'h0;  eye_width_q <= 7'h0;
            slip_q <= 4'h0;  cyc_q <= 1'b0;  stb_q <= 1'b0;  we_q <= 1'b0;  adr_q <= 6'h0;
            dat_q <= 32'h0;  sel_q <= 4'h0;  to_cnt_q <= 16'h0;  wait_q <= 32'h0;  tap_q <= 7'h0;
            rd_q <= 32'h0;  ctrl_q <= 32'h0;  run_start_q <= 6'h0;  run_len_q <= 7'h0;
            best_start_q <= 6'h0;  best_len_q <= 7'h0;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
            errmap_q <= '0;
`endif
        end else begin
            state_q <= state_d;  target_q <= target_d;  busy_q <= busy_d;  done_q <= done_d;
            fail_q <= fail_d;  code_q <= code_d;  best_delay_q <= best_delay_d;
            eye_width_q <= eye_width_d;  slip_q <= slip_d;  cyc_q <= cyc_d;  stb_q <= stb_d;
            we_q <= we_d;  adr_q <= adr_d;  dat_q <= dat_d;  sel_q <= sel_d;  to_cnt_q <= to_cnt_d;
            wait_q <= wait_d;  tap_q <= tap_d;  rd_q <= rd_d;  ctrl_q <= ctrl_d;
            run_start_q <= run_start_d;  run_len_q <= run_len_d;
            best_start_q <= best_start_d;  best_len_q <= best_len_d;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
            errmap_q <= errmap_d;
`endif
        end
    end

    assign busy_o = busy_q;  assign done_o = done_q;  assign fail_o = fail_q;
    assign fail_code_o = code_q;  assign best_delay_o = best_delay_q;
    assign eye_width_o = eye_width_q;  assign bitslip_count_o = slip_q;
    assign m_cyc_o = cyc_q;  assign m_stb_o = stb_q;  assign m_we_o = we_q;
    assign m_adr_o = adr_q;  assign m_dat_o = dat_q;  assign m_sel_o = sel_q;
`ifdef SURFCTL_ALIGN_ERRMAP_EN
    assign errmap_o = errmap_q;
`endif

endmodule

// File: tb/tb_surfctl_align_sequencer.sv
// Bench for surfctl_align_sequencer: register-core model, expected-transaction scoreboard, status checks.
module tb_surfctl_align_sequencer;

    typedef struct packed {
        logic        dc;
        logic        we;
        logic [5:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } txn_t;

    logic        clk, rst, start, target;
    logic        busy_o, done_o, fail_o;
    logic [1:0]  fail_code_o;
    logic [5:0]  best_delay_o;
    logic [6:0]  eye_width_o;
    logic [3:0]  bitslip_count_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [5:0]  m_adr_o;
    logic [31:0] m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_ack_i, m_err_i;

    int   vectors = 0, miscompares = 0;
    txn_t exp_q[$];

    logic [63:0] good_mask;
    int          slips_need, m_tap, m_slips;
    logic        bad_first, bad_done, withhold, freeze_rd;

    surfctl_align_sequencer #(.WAIT_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .target_i(target),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_code_o(fail_code_o),
        .best_delay_o(best_delay_o), .eye_width_o(eye_width_o), .bitslip_count_o(bitslip_count_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pw(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        exp_q.push_back('{dc: 1'b0, we: 1'b1, adr: adr, sel: sel, dat: dat});
    endtask
    task automatic pw_dc(input logic [5:0] adr);
        exp_q.push_back('{dc: 1'b1, we: 1'b1, adr: adr, sel: 4'hF, dat: 32'h0});
    endtask
    task automatic pr(input logic [5:0] adr);
        exp_q.push_back('{dc: 1'b1, we: 1'b0, adr: adr, sel: 4'hF, dat: 32'h0});
    endtask

    task automatic push_sweep(input logic [5:0] b);
        pw(b + 6'h08, 32'h0001_0000, 4'hF);
        for (int t = 0; t < 32; t++) begin
            pw(b + 6'h04, 32'(t), 4'hF);
            pr(b + 6'h08);
        end
    endtask

    task automatic model_cfg(input logic [63:0] mask, input int need);
        good_mask = mask;  slips_need = need;  m_tap = 0;  m_slips = 0;
        bad_first = 1'b0;  bad_done = 1'b0;  withhold = 1'b0;  freeze_rd = 1'b0;
    endtask

    task automatic do_start(input logic tgt);
        @(negedge clk);
        start = 1'b1;  target = tgt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done_o || fail_o) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            vectors++;  miscompares++;
            $display("FAIL end_timeout: got no done/fail expected completion within 5000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_status(input logic d, input logic f, input logic [1:0] code,
                              input logic [5:0] bd, input logic [6:0] ew, input logic [3:0] sc);
        chk("done", done_o, d);
        chk("fail", fail_o, f);
        chk("fail_code", fail_code_o, code);
        chk("busy", busy_o, 1'b0);
        if (d) begin
            chk("best_delay", best_delay_o, bd);
            chk("eye_width", eye_width_o, ew);
        end
        chk("bitslip_count", bitslip_count_o, sc);
        chk("txn_remaining", exp_q.size(), 0);
    endtask

    // Register-core model plus monitor: every acked transaction is matched against the queue.
    initial begin
        txn_t obs, e;
        m_ack_i = 1'b0;  m_err_i = 1'b0;  m_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !m_cyc_o || !m_stb_o || m_ack_i || withhold ||
                (freeze_rd && !m_we_o && m_adr_o[3:0] == 4'h8)) begin
                m_ack_i = 1'b0;
            end else begin
                obs = '{dc: 1'b0, we: m_we_o, adr: m_adr_o, sel: m_sel_o, dat: m_dat_o};
                if (exp_q.size() == 0) begin
                    vectors++;  miscompares++;
                    $display("FAIL txn_extra: got %0h expected none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.dc) obs.dat = 32'h0;
                    obs.dc = e.dc;
                    chk("txn", obs, e);
                end
                if (m_we_o) begin
                    if (m_adr_o[3:0] == 4'h4) m_tap = int'(m_dat_o[5:0]);
                    if (m_adr_o[3:0] == 4'hC) m_slips++;
                end else begin
                    case (m_adr_o[3:0])
                        4'h8: begin
                            if (bad_first && !bad_done) m_dat_i = 32'hFFFF_FFFF;
                            else m_dat_i = good_mask[m_tap] ? 32'd0 : 32'd500;
                            bad_done = 1'b1;
                        end
                        4'hC: if (m_adr_o[4])
                                  m_dat_i = (m_slips >= slips_need) ? 32'h1234_566A : 32'h1234_566B;
                              else
                                  m_dat_i = (m_slips >= slips_need) ? 32'hA55A_6996 : 32'hA55A_6997;
                        default: m_dat_i = 32'h0000_0400;
                    endcase
                end
                m_ack_i = 1'b1;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;  start = 1'b0;  target = 1'b0;
        model_cfg(64'h0, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, fail_o, fail_code_o, best_delay_o, eye_width_o,
            bitslip_count_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o}, 96'h0);
        rst = 1'b0;
        @(negedge clk);

        // COUT, good taps 10..21, lock after 2 slips; a start while busy must be ignored.
        model_cfg(64'h0000_0000_003F_FC00, 2);
        push_sweep(6'h00);
        pw(6'h04, 32'd16, 4'hF);
        pr(6'h0C); pw_dc(6'h0C); pr(6'h0C); pw_dc(6'h0C); pr(6'h0C);
        pr(6'h00);
        pw(6'h00, 32'h0000_0500, 4'b0010);
        do_start(1'b0);
        chk("busy_after_start", busy_o, 1'b1);
        repeat (20) @(negedge clk);
        do_start(1'b1);
        wait_end();
        chk_status(1'b1, 1'b0, 2'd0, 6'd16, 7'd12, 4'd2);

        // DOUT, equal runs 2..6 and 20..24: earliest wins.
        model_cfg(64'h0000_0000_01F0_007C, 0);
        push_sweep(6'h10);
        pw(6'h14, 32'd4, 4'hF);
        pr(6'h1C);
        pr(6'h10);
        pw(6'h10, 32'h0000_0500, 4'b0010);
        do_start(1'b1);
        wait_end();
        chk_status(1'b1, 1'b0, 2'd0, 6'd4, 7'd5, 4'd0);

        // Only taps 0..2 good: eye too narrow.
        model_cfg(64'h7, 0);
        push_sweep(6'h00);
        do_start(1'b0);
        wait_end();
        chk_status(1'b0, 1'b1, 2'd2, 6'd0, 7'd0, 4'd0);
        chk("narrow_eye_width", eye_width_o, 7'd3);

        // Pattern never matches: 8 slips, then lock failure.
        model_cfg(64'h0000_0000_003F_FC00, 99);
        push_sweep(6'h00);
        pw(6'h04, 32'd16, 4'hF);
        for (int i = 0; i < 8; i++) begin
            pr(6'h0C);
            pw_dc(6'h0C);
        end
        pr(6'h0C);
        do_start(1'b0);
        wait_end();
        chk_status(1'b0, 1'b1, 2'd3, 6'd0, 7'd0, 4'd8);

        // First count read returns all-ones: bus fault.
        model_cfg(64'h0000_0000_003F_FC00, 0);
        bad_first = 1'b1;
        pw(6'h08, 32'h0001_0000, 4'hF);
        pw(6'h04, 32'd0, 4'hF);
        pr(6'h08);
        do_start(1'b0);
        wait_end();
        chk_status(1'b0, 1'b1, 2'd1, 6'd0, 7'd0, 4'd0);

        // Withheld ack: the cycle stays up for WB_TIMEOUT cycles, then faults.
        model_cfg(64'h0, 0);
        withhold = 1'b1;
        do_start(1'b0);
        n = 0;
        for (int i = 0; i < 600 && !fail_o; i++) begin
            if (m_cyc_o) n++;
            @(negedge clk);
        end
        chk("timeout_cyc_cycles", n, 255);
        chk("timeout_cyc_dropped", m_cyc_o, 1'b0);
        chk_status(1'b0, 1'b1, 2'd1, 6'd0, 7'd0, 4'd0);

        // Reset during the first count read.
        model_cfg(64'h0, 0);
        freeze_rd = 1'b1;
        pw(6'h08, 32'h0001_0000, 4'hF);
        pw(6'h04, 32'd0, 4'hF);
        do_start(1'b0);
        n = 0;
        while (!(m_cyc_o && !m_we_o && m_adr_o == 6'h08) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("tap_rd_reached", n < 500, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_cyc", m_cyc_o, 1'b0);
        chk("reset_mid_outputs", {busy_o, done_o, fail_o, fail_code_o, best_delay_o, eye_width_o,
            bitslip_count_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o}, 96'h0);
        chk("reset_mid_txn_remaining", exp_q.size(), 0);
        rst = 1'b0;
        freeze_rd = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
